// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg: shared constants and receiver state encoding            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 2170;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_fifo: first-word-fall-through byte buffer                 |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [UART_DATA_BITS-1:0] head
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [PW:0]               r_count;
    logic                      w_wr;
    logic                      w_rd;

    assign full  = (r_count == (PW+1)'(FIFO_DEPTH));
    assign empty = (r_count == '0);
    // Gate the head so rx_data reads zero whenever nothing is buffered.
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_deser: 8N1 (8E1 with UART_RX_PARITY_EN) serial receiver   |
// | feeding a FWFT byte FIFO. Rev 1.0                                 |
// +------------------------------------------------------------------+
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam int          BW        = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] C_HALF_TC = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] C_FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    uart_rx_state_e            r_state;
    uart_rx_state_e            w_state_nxt;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_cnt_nxt;
    logic [BW-1:0]             r_bits;
    logic [BW-1:0]             w_bits_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      r_frame_err;
    logic                      w_fe_nxt;
    logic                      r_overrun;
    logic                      w_ov_nxt;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_rxs;
    logic                      w_tick;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad;
    logic                      w_par_bad_nxt;
    logic                      r_parity_err;
    logic                      w_pe_nxt;
`endif

    assign w_rxs  = r_sync2;
    assign w_tick = (r_cnt == C_FULL_TC);
    assign w_pop  = rx_valid && rx_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_fe_nxt    = 1'b0;
        w_ov_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_pe_nxt      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_bits_nxt  = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == C_HALF_TC) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                    w_bits_nxt  = r_bits + BW'(1);
                    if (r_bits == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt     = '0;
                    w_par_bad_nxt = ^{r_shift, w_rxs};
                    w_state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    // A bad stop bit wins over any parity verdict for the frame.
                    if (!w_rxs) begin
                        w_fe_nxt    = 1'b1;
                        w_state_nxt = ST_WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (r_par_bad) begin
                        w_pe_nxt = 1'b1;
                    end
`endif
                    else begin
                        w_push   = 1'b1;
                        w_ov_nxt = w_full && !w_pop;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_rxs) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bits      <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_bits      <= w_bits_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_fe_nxt;
            r_overrun   <= w_ov_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_pe_nxt;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (rx_data)
    );

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_rx_deser: randomized frames against a byte-level model    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_uart_rx_deser;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int C_LATENCY = 2 + CPB/2 + 10*CPB + 1;
`else
    localparam int C_LATENCY = 2 + CPB/2 + 9*CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       pe;
    logic       ov;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_deser #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .uart_rx    (rxd),
        .rx_data    (data),
        .rx_valid   (valid),
        .rx_ready   (ready),
        .frame_err  (fe),
        .parity_err (pe),
        .overrun    (ov),
        .busy       (busy)
    );

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt, pe_cnt, ov_cnt, valid_cyc, first_valid_cyc, start_cyc;
    bit         rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) got_q.push_back(data);
            if (valid) begin
                if (valid_cyc == 0) first_valid_cyc = cyc;
                valid_cyc++;
            end
            fe_cnt += int'(fe);
            pe_cnt += int'(pe);
            ov_cnt += int'(ov);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_stats();
        got_q.delete();
        fe_cnt = 0; pe_cnt = 0; ov_cnt = 0; valid_cyc = 0; first_valid_cyc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop_v);
        rxd = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  32'(data),  32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_fe"},    32'(fe),    32'h0);
        check({tag, "_pe"},    32'(pe),    32'h0);
        check({tag, "_ov"},    32'(ov),    32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
    endtask

    initial begin
        int gap;
        logic [7:0] b;
        bit bad;
        int exp_fe;

        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) step();
        clear_stats();

        // Basic byte with latency measured from the pin falling edge
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) step();
        check("basic_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("basic_data", 32'(got_q[0]), 32'hA5);
        check("basic_latency", 32'(first_valid_cyc - start_cyc), 32'(C_LATENCY));
        check("basic_valid_width", 32'(valid_cyc), 32'd1);
        check("basic_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        // Start-bit glitch
        clear_stats();
        rxd = 1'b0;
        repeat (4) step();
        check("glitch_busy_hi", 32'(busy), 32'd1);
        rxd = 1'b1;
        repeat (10) step();
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_valid", 32'(valid_cyc), 32'd0);
        check("glitch_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        // Framing error followed by a held-low break
        clear_stats();
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) step();
        rxd = 1'b1;
        repeat (5) step();
        check("frame_err_count", 32'(fe_cnt), 32'd1);
        check("frame_no_byte", 32'(valid_cyc), 32'd0);
        check("frame_pe", 32'(pe_cnt), 32'd0);
        send_frame(8'h11, 1'b1, 1'b0);
        repeat (3) step();
        check("after_fe_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("after_fe_data", 32'(got_q[0]), 32'h11);

        // Overrun with a stalled consumer
        clear_stats();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 4) check("ovr_before", 32'(ov_cnt), 32'd0);
        end
        repeat (2) step();
        check("ovr_count", 32'(ov_cnt), 32'd1);
        ready = 1'b1;
        repeat (10) step();
        check("ovr_drain_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("ovr_drain_data", 32'(got_q[i]), 32'(i + 1));

        // Reset during data bit 3 discards partial frame and FIFO contents
        clear_stats();
        ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        repeat (2) step();
        check("rst_pre_valid", 32'(valid), 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rxd = 1'b1;
        repeat (CPB/2) step();
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        repeat (3) step();
        check_outputs_zero("rst_hold");
        rst = 1'b0;
        ready = 1'b1;
        repeat (2*CPB) step();
        clear_stats();
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (3) step();
        check("rst_after_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("rst_after_data", 32'(got_q[0]), 32'h5A);

`ifdef UART_RX_PARITY_EN
        clear_stats();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (3) step();
        check("par_err_count", 32'(pe_cnt), 32'd1);
        check("par_err_no_byte", 32'(valid_cyc), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (3) step();
        check("par_ok_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("par_ok_data", 32'(got_q[0]), 32'h07);
`endif

        // Randomized frames, random gaps and a jittery consumer
        clear_stats();
        exp_q.delete();
        exp_fe = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 14; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad, 1'b0);
            if (bad) begin
                exp_fe++;
                gap = $urandom_range(3, 20);
            end else begin
                exp_q.push_back(b);
                gap = $urandom_range(0, 20);
            end
            repeat (gap) step();
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        repeat (10) step();
        check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("rand_data", 32'(got_q[i]), 32'(exp_q[i]));
        check("rand_fe", 32'(fe_cnt), 32'(exp_fe));
        check("rand_pe", 32'(pe_cnt), 32'd0);
        check("rand_ov", 32'(ov_cnt), 32'd0);
        check("rand_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_deser.md
# uart_rx_deser

Asynchronous-serial receiver that deserializes 8N1 frames from the board `uart_rx` pin (115200 baud at 250 MHz by default) into bytes and buffers them in a small FIFO. A valid/ready byte stream feeds the control/debug path inside `fpga_top`. It is the receive-side counterpart of the existing UART transmit path. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 2170, clock cycles per bit (250e6/115200); must be ≥ 8.
- `FIFO_DEPTH`, 4, byte buffer entries; power of two, ≥ 2.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  raw serial line, idle high, asynchronous to `clock`.
- `rx_data`  out  8  head-of-FIFO byte; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; constant 0 without the macro.
- `overrun`  out  1  one-cycle pulse: a good byte arrived with the FIFO full and was dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input sync:** `uart_rx` passes through a 2-flop synchronizer reset to 1. All decisions use the synchronized value `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- **IDLE:** on `rxs == 0`, clear the bit counter and go to START.
- **START:** count `CLKS_PER_BIT/2` cycles (integer floor), then sample. If `rxs == 1`, treat it as a glitch and return to IDLE with no flags. Otherwise go to DATA.
- **DATA:** sample every `CLKS_PER_BIT` cycles, 8 samples, LSB first, shifted into the shift register. After the 8th sample go to PARITY or STOP.
- **PARITY:** after `CLKS_PER_BIT` cycles, sample the parity bit. Even parity: the XOR of the 8 data bits and the parity bit must be 0. The result is latched and applied at STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, sample the stop bit.
  - `rxs == 0`: pulse `frame_err`, drop the byte, go to WAIT_HIGH.
  - Parity mismatch (and stop bit good): pulse `parity_err`, drop the byte, go to IDLE.
  - Stop bit good and parity good: push the byte. If the FIFO is full and not popping this cycle, pulse `overrun` and drop the byte. Go to IDLE.
  - A `frame_err` suppresses `parity_err` for the same frame.
- **WAIT_HIGH:** stay until `rxs == 1`, then IDLE. A line held low (break) produces exactly one `frame_err`.
- **FIFO:** first-word-fall-through.
  - `rx_data` is the head entry.
  - A pop happens on `rx_valid && rx_ready`.
  - Push and pop in the same cycle: both take effect, occupancy is unchanged, and there is no overrun even when full.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- **Bit counter:** width is `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1, and the sample occurs on the terminal count.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0. Synchronizer flops = 1, FSM = IDLE, FIFO empty.
- **Reset behaviour:** reset asserted mid-frame discards the partial byte and FIFO contents immediately. After deassertion, the block waits in IDLE for the next falling edge.
- **Sample points:** the first data sample falls `CLKS_PER_BIT/2 + CLKS_PER_BIT` cycles after IDLE sees `rxs == 0`. The stop sample falls at `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` (plus `CLKS_PER_BIT` with parity).
- **Pin-to-byte latency:** `rx_valid` rises 1 cycle after the stop sample. From the pin falling edge, add 2 synchronizer cycles.
- **Error pulses:** all are exactly 1 cycle wide, in the cycle after the relevant sample.
- **Back-to-back frames:** a new start bit is detected on the first IDLE cycle. No idle gap is required.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the frame is 8E1. The PARITY state and `parity_err` logic are present.
- **`UART_RX_PARITY_EN` undefined:** the frame is 8N1. The PARITY state is absent, STOP follows DATA directly, and `parity_err` is tied to 0.

## Structure
- **Package `uart_pkg`:**
  - State enum `uart_rx_state_e`.
  - `UART_DATA_BITS = 8`.
  - `UART_DEFAULT_CLKS_PER_BIT = 2170`.
- **Sub-module `uart_rx_fifo`:** parameterized by `FIFO_DEPTH`, 8-bit FWFT. It exposes `push`, `pop`, `full`, `empty` and `head` with the same clock and reset. The synchronizer and FSM stay in `uart_rx_deser`.

## Test plan
All scenarios use `CLKS_PER_BIT=16`, `FIFO_DEPTH=4`.
- **Basic byte:** send 0xA5 8N1 with `rx_ready=1` → `rx_data=0xA5` with `rx_valid` high for 1 cycle, at 2+8+144+1 cycles after the falling edge. No error pulses.
- **Start glitch:** drive the line low for 4 cycles, then high → no `rx_valid`, no errors, `busy` back to 0 within 10 cycles.
- **Framing error:** send 0x3C with the stop bit 0, then hold low for 40 cycles → exactly one `frame_err` pulse and no byte. The next valid frame 0x11 is received.
- **Overrun:** hold `rx_ready=0` and send 0x01..0x05 → `overrun` pulses once on the 5th frame. Draining yields 0x01, 0x02, 0x03, 0x04.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → all outputs are 0 while reset is high. The next frame 0x5A is received correctly.
- **Parity (macro on):** send 0x07 with parity bit 0 → one `parity_err` pulse and no byte. Then send 0x07 with parity bit 1 → `rx_data=0x07`.
